if_fetch_pc: RTL
================

// Module: if_fetch_pc
// PURPOSE
//  Fetch-side producer for the IF/ID pipeline register. Owns the program counter and runs the
//  instruction-memory request/ack handshake. Presents if_pc/if_inst to IF/ID each cycle.
//  Applies the global stall vector, exception flush and ID-stage branch redirects.
//  Raises stallreq_if while a fetch is outstanding.
// PARAMETERS
//  RESET_PC    32'hBFC0_0000  PC value loaded on reset
//  ADDR_W      32             instruction address width
//  DATA_W      32             instruction word width
// PORTS
//  clk             in   1       system clock; all state updates on posedge
//  rst             in   1       asynchronous, active-low reset (rst==0 resets)
//  stall           in   6       global stall vector; stall[0] = PC stage
//  flush           in   1       exception flush; redirect to new_pc
//  new_pc          in   ADDR_W  exception/ERET target
//  branch_flag_i   in   1       ID-stage taken branch/jump
//  branch_addr_i   in   ADDR_W  branch/jump target
//  inst_req        out  1       memory request valid
//  inst_addr       out  ADDR_W  memory request address (word aligned)
//  inst_ack        in   1       memory returns inst_rdata this cycle
//  inst_rdata      in   DATA_W  fetched instruction
//  if_pc           out  ADDR_W  PC of the instruction offered to IF/ID
//  if_inst         out  DATA_W  instruction offered to IF/ID (0 = bubble)
//  stallreq_if     out  1       fetch pending; controller must stall PC and IF
// BEHAVIOUR
//  Reset (async, rst==0):
//   - pc=RESET_PC, state=IDLE, inst_req=0, if_pc=0, if_inst=0, stallreq_if=0, redirect latch cleared.
//   - First request issues the cycle after reset is released.
//  FSM states:
//   - IDLE: inst_req=0. Move to REQ next cycle unless stall[0]=1.
//   - REQ: inst_req=1, inst_addr=pc, held stable until ack. stallreq_if=~inst_ack.
//       - On ack: if_pc<=pc, if_inst<=inst_rdata; pc<=next_pc. Remain in REQ for back-to-back fetch (1/cycle).
//       - If stall[0]=1 at ack: capture data into a hold buffer, go to HOLD.
//   - HOLD: inst_req=0. Buffered word is re-presented while stall[0]=1. Return to REQ when stall[0]=0.
//   - DROP: request outstanding when a redirect arrived. inst_req stays 1 with the old address.
//       - On ack: data discarded, if_inst=0, pc<=redirect latch, go to REQ.
//  next_pc priority:
//   - flush > branch_flag_i > stall[0] (hold) > pc+4.
//   - pc+4 wraps modulo 2^ADDR_W.
//  Redirect handling:
//   - Redirect with no outstanding request: pc loaded next cycle and if_inst forced to 0.
//   - Redirect while REQ unacked: target latched, go to DROP.
//   - Redirect arriving in DROP overwrites the latch. flush wins over a simultaneous branch.
//   - flush in any state forces if_inst=0/if_pc=0 next cycle, matching the IF/ID bubble.
//  Simultaneous events:
//   - ack with branch_flag_i in REQ: fetched word is the delay slot and is delivered; pc<=branch_addr_i.
//   - ack with flush: word discarded, pc<=new_pc.
//  Bubbles: stall[0]=1 with stall[1]=0 gives if_inst=0 to IF/ID; the PC is unchanged.
//  Misaligned target (addr[1:0]!=0): accepted, and inst_addr forces [1:0]=0.
//  Address-error exceptions are raised downstream, not here.
// STRUCTURE
//  Shared package/Defines.vh holds:
//   - state encodings FS_IDLE/FS_REQ/FS_HOLD/FS_DROP
//   - RstEnable (1'b0 for this block), Stop/NoStop, ZeroWord, InstAddrBus, InstBus
//  One natural sub-module: fetch_redirect_latch. It stores the pending target plus a valid bit
//  and resolves flush-over-branch priority.
// TESTING
//  1. Reset release, ack every cycle -> inst_addr BFC00000, BFC00004, BFC00008; if_pc follows 1 cycle later.
//  2. ack delayed 3 cycles on addr BFC00004 -> inst_req/addr held; stallreq_if=1 for 3 cycles, then 0.
//  3. branch_flag_i=1, target 8000_0100, in the ack cycle of BFC00008 -> delay slot delivered; next addr 8000_0100.
//  4. flush, new_pc=BFC00380, while REQ unacked -> DROP; acked word dropped (if_inst=0); next addr BFC00380.
//  5. stall[0]=1 at ack, held 2 cycles -> HOLD; same if_inst re-presented; resume at pc+4 with no lost word.
//  6. rst low mid-DROP with pending redirect -> all outputs 0, pc=BFC00000, latch cleared, first req after release.

Source files
------------

// File: rtl/if_fetch_pc_pkg.sv
// Shared definitions for the fetch-side PC block: widths, reset/stall polarities
// and the fetch handshake state encoding.
package if_fetch_pc_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic RstEnable = 1'b0;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam logic [INST_W-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_pc_redirect_latch.sv
// Pending-redirect store: resolves flush-over-branch priority and keeps the target
// that must be loaded once an in-flight fetch has been acknowledged and discarded.
module if_fetch_pc_redirect_latch
    import if_fetch_pc_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              capture,
    input  logic              clear,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_target,
    output logic              pending_valid,
    output logic [ADDR_W-1:0] pending_target
);

    logic              valid_r;
    logic [ADDR_W-1:0] target_r;

    // Resolve this cycle's redirect; flush beats a simultaneous branch.
    always_comb begin
        redirect = flush | branch_flag;
        if (flush) begin
            redirect_target = new_pc;
        end else if (branch_flag) begin
            redirect_target = branch_addr;
        end else begin
            redirect_target = target_r;
        end
    end

    // Latch storage; a later capture simply overwrites an earlier target.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            valid_r  <= 1'b0;
            target_r <= '0;
        end else if (capture && redirect) begin
            valid_r  <= 1'b1;
            target_r <= redirect_target;
        end else if (clear) begin
            valid_r  <= 1'b0;
            target_r <= '0;
        end else begin
            valid_r  <= valid_r;
            target_r <= target_r;
        end
    end

    assign pending_valid  = valid_r;
    assign pending_target = target_r;

endmodule

// File: rtl/if_fetch_pc.sv
// Fetch-side producer for IF/ID: owns the PC, runs the instruction-memory req/ack
// handshake and applies stall, flush and branch redirects.
module if_fetch_pc
    import if_fetch_pc_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ack,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              stallreq_if
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

    fetch_state_e      state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] if_pc_r, if_pc_s;
    logic [DATA_W-1:0] if_inst_r, if_inst_s;
    logic              fetching_s;
    logic              stall_pc_s;
    logic              redirect_s;
    logic [ADDR_W-1:0] redirect_target_s;
    logic              pending_valid_s;
    logic [ADDR_W-1:0] pending_target_s;
    logic              latch_capture_s;
    logic              latch_clear_s;
    logic              stall_unused_s;

    if_fetch_pc_redirect_latch #(
        .ADDR_W (ADDR_W)
    ) u_redirect_latch (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag     (branch_flag_i),
        .branch_addr     (branch_addr_i),
        .capture         (latch_capture_s),
        .clear           (latch_clear_s),
        .redirect        (redirect_s),
        .redirect_target (redirect_target_s),
        .pending_valid   (pending_valid_s),
        .pending_target  (pending_target_s)
    );

    // Later pipeline stages handle their own stall bits.
    assign stall_unused_s = ^stall[5:1];
    assign stall_pc_s     = (stall[0] == Stop);

    assign fetching_s  = (state_r == FS_REQ) || (state_r == FS_DROP);
    assign inst_req    = fetching_s;
    assign inst_addr   = {pc_r[ADDR_W-1:2], 2'b00};
    assign stallreq_if = fetching_s & ~inst_ack;
    assign if_pc       = if_pc_r;
    assign if_inst     = if_inst_r;

    // Next state, next PC and the word offered to IF/ID (bubble unless delivered or held).
    always_comb begin
        state_s         = state_r;
        pc_s            = pc_r;
        if_pc_s         = '0;
        if_inst_s       = DATA_W'(ZeroWord);
        latch_capture_s = 1'b0;
        latch_clear_s   = 1'b0;
        case (state_r)
            FS_IDLE: begin
                if (redirect_s) begin
                    pc_s = redirect_target_s;
                end else begin
                    pc_s = pc_r;
                end
                state_s = (stall[0] == NoStop) ? FS_REQ : FS_IDLE;
            end
            FS_REQ: begin
                if (inst_ack && flush) begin
                    pc_s    = redirect_target_s;
                    state_s = stall_pc_s ? FS_IDLE : FS_REQ;
                end else if (inst_ack) begin
                    // A branch in the ack cycle means this word is its delay slot.
                    if_pc_s   = pc_r;
                    if_inst_s = inst_rdata;
                    pc_s      = branch_flag_i ? branch_addr_i : pc_r + PC_STEP;
                    state_s   = stall_pc_s ? FS_HOLD : FS_REQ;
                end else if (redirect_s) begin
                    latch_capture_s = 1'b1;
                    state_s         = FS_DROP;
                end else begin
                    state_s = FS_REQ;
                end
            end
            FS_HOLD: begin
                // The IF/ID output registers double as the hold buffer.
                if (redirect_s) begin
                    pc_s    = redirect_target_s;
                    state_s = stall_pc_s ? FS_IDLE : FS_REQ;
                end else if (stall_pc_s) begin
                    if_pc_s   = if_pc_r;
                    if_inst_s = if_inst_r;
                    state_s   = FS_HOLD;
                end else begin
                    state_s = FS_REQ;
                end
            end
            FS_DROP: begin
                if (inst_ack) begin
                    latch_clear_s = 1'b1;
                    if (redirect_s) begin
                        pc_s = redirect_target_s;
                    end else if (pending_valid_s) begin
                        pc_s = pending_target_s;
                    end else begin
                        pc_s = pc_r;
                    end
                    state_s = stall_pc_s ? FS_IDLE : FS_REQ;
                end else begin
                    latch_capture_s = redirect_s;
                    state_s         = FS_DROP;
                end
            end
            default: begin
                state_s = FS_IDLE;
            end
        endcase
    end

    // State, PC and IF/ID-facing registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_r   <= FS_IDLE;
            pc_r      <= RESET_PC;
            if_pc_r   <= '0;
            if_inst_r <= '0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            if_pc_r   <= if_pc_s;
            if_inst_r <= if_inst_s;
        end
    end

endmodule
